if_fetch_ctrl: RTL and testbench

// Fetch sequencer for the RV32I IF stage. Owns the PC and drives a synchronous instruction memory through a req/gnt handshake.

---
 rtl/if_fetch_ctrl_pkg.sv | 12 +
 rtl/if_skid_buf.sv | 43 ++++
 rtl/if_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package if_fetch_ctrl_pkg;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] RV32I_NOP = 32'h00000013;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register for responses that land while ID stalls.
module if_skid_buf #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [DATA_W-1:0] i_instr,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_instr
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_instr;

  // Clear (flush) wins over load, load wins over drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/if_fetch_ctrl.sv
// RV32I IF-stage fetch sequencer: PC ownership, IMEM req/gnt handshake,
// one-entry skid buffer and registered IF/ID triple.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned                REG_DATA_WIDTH  = 32,
  parameter int unsigned                IMEM_ADDR_WIDTH = 32,
  parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int unsigned                BOOT_CYCLES     = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [IMEM_ADDR_WIDTH-1:0] EX_PC_Branch_dest,
  input  logic                       EX_PC_Source_sel,
  input  logic                       IF_Stall,
  output logic                       IMEM_Req,
  output logic [IMEM_ADDR_WIDTH-1:0] IMEM_Addr,
  input  logic                       IMEM_Gnt,
  input  logic [REG_DATA_WIDTH-1:0]  IMEM_Rdata,
  output logic [IMEM_ADDR_WIDTH-1:0] IF_PC,
  output logic [REG_DATA_WIDTH-1:0]  IF_Instruction,
  output logic                       IF_Valid,
  output logic                       IF_Misalign
);

  localparam int unsigned BOOT_CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_CNT_W-1:0]      BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);
  localparam logic [REG_DATA_WIDTH-1:0]  NOP       = REG_DATA_WIDTH'(RV32I_NOP);
  localparam logic [IMEM_ADDR_WIDTH-1:0] PC_STEP   = IMEM_ADDR_WIDTH'(4);

  fetch_state_t               r_state;
  logic [BOOT_CNT_W-1:0]      r_boot_cnt;
  logic [IMEM_ADDR_WIDTH-1:0] r_pc;
  logic                       r_inflight;
  logic [IMEM_ADDR_WIDTH-1:0] r_inflight_pc;
  logic [IMEM_ADDR_WIDTH-1:0] r_if_pc;
  logic [REG_DATA_WIDTH-1:0]  r_if_instr;
  logic                       r_if_valid;
  logic                       r_misalign;

  logic                       w_req;
  logic                       w_grant;
  logic [IMEM_ADDR_WIDTH-1:0] w_redirect_pc;
  logic                       w_buf_valid;
  logic [IMEM_ADDR_WIDTH-1:0] w_buf_pc;
  logic [REG_DATA_WIDTH-1:0]  w_buf_instr;

  // Holding off the request while a stalled response is inflight, or while
  // the buffer is occupied, keeps at most one unconsumed response around.
  assign w_req         = (r_state == S_RUN) & ~w_buf_valid & ~EX_PC_Source_sel
                         & ~(IF_Stall & r_inflight);
  assign w_grant       = w_req & IMEM_Gnt;
  assign w_redirect_pc = {EX_PC_Branch_dest[IMEM_ADDR_WIDTH-1:2], 2'b00};

  // Boot settle counter, then run until reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_boot_cnt <= r_boot_cnt + BOOT_CNT_W'(1);
          if (r_boot_cnt == BOOT_LAST) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // PC advance on grant, redirect load, and inflight tracking.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (EX_PC_Source_sel) begin
      r_pc       <= w_redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_pc          <= r_pc + PC_STEP;
        r_inflight_pc <= r_pc;
      end
    end
  end

  // Skid buffer catches a response arriving under stall; flushed on redirect.
  if_skid_buf #(
    .PC_W   (IMEM_ADDR_WIDTH),
    .DATA_W (REG_DATA_WIDTH)
  ) u_skid (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_load  (IF_Stall & r_inflight),
    .i_drain (~IF_Stall & w_buf_valid),
    .i_clear (EX_PC_Source_sel),
    .i_pc    (r_inflight_pc),
    .i_instr (IMEM_Rdata),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_instr (w_buf_instr)
  );

  // IF/ID output triple: buffer first, then live response, else bubble.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_if_pc    <= '0;
      r_if_instr <= NOP;
      r_if_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= EX_PC_Source_sel & (EX_PC_Branch_dest[1:0] != 2'b00);
      if (EX_PC_Source_sel) begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP;
      end else if (!IF_Stall) begin
        if (w_buf_valid) begin
          r_if_pc    <= w_buf_pc;
          r_if_instr <= w_buf_instr;
          r_if_valid <= 1'b1;
        end else if (r_inflight) begin
          r_if_pc    <= r_inflight_pc;
          r_if_instr <= IMEM_Rdata;
          r_if_valid <= 1'b1;
        end else begin
          r_if_instr <= NOP;
          r_if_valid <= 1'b0;
        end
      end
    end
  end

  assign IMEM_Req       = w_req;
  assign IMEM_Addr      = r_pc;
  assign IF_PC          = r_if_pc;
  assign IF_Instruction = r_if_instr;
  assign IF_Valid       = r_if_valid;
  assign IF_Misalign    = r_misalign;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: queue-based reference model plus directed pins
// and randomized traffic.
module tb_if_fetch_ctrl;

  localparam int          BOOT = 4;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        Clk;
  logic        Reset_n;
  logic [31:0] EX_PC_Branch_dest;
  logic        EX_PC_Source_sel;
  logic        IF_Stall;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Gnt;
  logic [31:0] IMEM_Rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        IF_Valid;
  logic        IF_Misalign;

  if_fetch_ctrl #(
    .REG_DATA_WIDTH  (32),
    .IMEM_ADDR_WIDTH (32),
    .RESET_PC        (32'h0),
    .BOOT_CYCLES     (BOOT)
  ) dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .EX_PC_Branch_dest (EX_PC_Branch_dest),
    .EX_PC_Source_sel  (EX_PC_Source_sel),
    .IF_Stall          (IF_Stall),
    .IMEM_Req          (IMEM_Req),
    .IMEM_Addr         (IMEM_Addr),
    .IMEM_Gnt          (IMEM_Gnt),
    .IMEM_Rdata        (IMEM_Rdata),
    .IF_PC             (IF_PC),
    .IF_Instruction    (IF_Instruction),
    .IF_Valid          (IF_Valid),
    .IF_Misalign       (IF_Misalign)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Fetched-but-not-delivered instructions, oldest first, tagged with grant cycle.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          gcyc;
  } ent_t;

  ent_t        q[$];
  int          n_tests;
  int          n_fail;
  int          cyc;
  int          m_cycles;
  logic [31:0] m_pc;
  logic [31:0] m_opc;
  logic [31:0] m_oinstr;
  logic        m_ovalid;
  logic        m_mis;
  logic        prev_grant;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Request allowed when running, not redirecting, nothing waiting from an
  // earlier cycle, and not (stalled with a response landing now).
  function automatic logic model_req(input logic stall, input logic sel);
    logic has_buf;
    logic has_arr;
    has_buf = (q.size() > 0) && (q[0].gcyc < cyc - 1);
    has_arr = (q.size() > 0) && (q[q.size()-1].gcyc == cyc - 1);
    return (m_cycles >= BOOT) && !sel && !has_buf && !(stall && has_arr);
  endfunction

  task automatic model_reset();
    q.delete();
    cyc        = 0;
    m_cycles   = 0;
    m_pc       = 32'h0;
    m_opc      = 32'h0;
    m_oinstr   = NOP;
    m_ovalid   = 1'b0;
    m_mis      = 1'b0;
    prev_grant = 1'b0;
    prev_addr  = 32'h0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational request, then advance the model at the rising edge.
  task automatic step(input logic stall, input logic sel, input logic [31:0] dest,
                      input logic gnt, output logic req_seen);
    logic mreq;
    logic grant;
    ent_t e;
    @(negedge Clk);
    chk("if_valid", 32'(IF_Valid), 32'(m_ovalid));
    chk("if_instr", IF_Instruction, m_oinstr);
    chk("if_pc", IF_PC, m_opc);
    chk("if_misalign", 32'(IF_Misalign), 32'(m_mis));
    IF_Stall          = stall;
    EX_PC_Source_sel  = sel;
    EX_PC_Branch_dest = dest;
    IMEM_Gnt          = gnt;
    IMEM_Rdata        = prev_grant ? mem(prev_addr) : $urandom();
    #1;
    mreq = model_req(stall, sel);
    chk("imem_req", 32'(IMEM_Req), 32'(mreq));
    chk("imem_addr", IMEM_Addr, m_pc);
    req_seen = IMEM_Req;
    @(posedge Clk);
    grant = mreq & gnt;
    m_cycles++;
    prev_grant = grant;
    prev_addr  = m_pc;
    if (sel) begin
      q.delete();
      m_ovalid = 1'b0;
      m_oinstr = NOP;
      m_mis    = (dest[1:0] != 2'b00);
      m_pc     = {dest[31:2], 2'b00};
    end else begin
      m_mis = 1'b0;
      if (!stall) begin
        if (q.size() > 0) begin
          e        = q.pop_front();
          m_opc    = e.pc;
          m_oinstr = e.instr;
          m_ovalid = 1'b1;
        end else begin
          m_ovalid = 1'b0;
          m_oinstr = NOP;
        end
      end
      if (grant) begin
        e.pc    = m_pc;
        e.instr = mem(m_pc);
        e.gcyc  = cyc;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Assert reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(IF_Valid), 32'h0);
    chk("rst_instr", IF_Instruction, NOP);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_misalign", 32'(IF_Misalign), 32'h0);
    chk("rst_req", 32'(IMEM_Req), 32'h0);
    chk("rst_addr", IMEM_Addr, 32'h0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic        r;
    logic        st;
    logic        sl;
    logic        gn;
    logic [31:0] dst;
    n_tests           = 0;
    n_fail            = 0;
    Reset_n           = 1'b0;
    IF_Stall          = 1'b0;
    EX_PC_Source_sel  = 1'b0;
    EX_PC_Branch_dest = 32'h0;
    IMEM_Gnt          = 1'b0;
    IMEM_Rdata        = 32'h0;
    model_reset();
    do_reset();

    // Boot with grant held: first request in cycle 4, first valid in cycle 6.
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, r);
      if (c == 3) chk("boot_req_c3", 32'(r), 32'h0);
      if (c == 4) chk("boot_req_c4", 32'(r), 32'h1);
      if (c == 5) begin
        #1;
        chk("first_valid", 32'(IF_Valid), 32'h1);
        chk("first_pc", IF_PC, 32'h0);
        chk("first_instr", IF_Instruction, mem(32'h0));
      end
      if (c == 6) begin
        #1;
        chk("second_pc", IF_PC, 32'h4);
      end
    end

    // Three-cycle stall: triple holds at PC 0x10, PC 0x14 lands in the buffer.
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h0, 1'b1, r);
    #1;
    chk("stall_hold_pc", IF_PC, 32'h10);
    chk("stall_hold_valid", 32'(IF_Valid), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, r);
    #1;
    chk("drain_pc", IF_PC, 32'h14);
    step(1'b0, 1'b0, 32'h0, 1'b1, r);
    #1;
    chk("drain_bubble", 32'(IF_Valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, r);
    #1;
    chk("after_drain_pc", IF_PC, 32'h18);

    // Fill the buffer under stall, then redirect to 0x100 while still stalled.
    step(1'b1, 1'b0, 32'h0, 1'b1, r);
    step(1'b1, 1'b1, 32'h100, 1'b1, r);
    #1;
    chk("redir_valid", 32'(IF_Valid), 32'h0);
    chk("redir_addr", IMEM_Addr, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1, r);
    step(1'b0, 1'b0, 32'h0, 1'b1, r);
    #1;
    chk("redir_first_pc", IF_PC, 32'h100);
    chk("redir_first_valid", 32'(IF_Valid), 32'h1);

    // Misaligned redirect: aligned address and a single-cycle pulse.
    step(1'b0, 1'b1, 32'h102, 1'b1, r);
    #1;
    chk("mis_addr", IMEM_Addr, 32'h100);
    chk("mis_pulse", 32'(IF_Misalign), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, r);
    #1;
    chk("mis_pulse_end", 32'(IF_Misalign), 32'h0);

    // Grant withheld for five cycles: request stays up at a stable address.
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, r);
      chk("gnt_low_req", 32'(r), 32'h1);
    end
    #1;
    chk("gnt_low_addr", IMEM_Addr, 32'h104);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'h0, 1'b1, r);

    // Address wrap at the top of the space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, r);
    step(1'b0, 1'b0, 32'h0, 1'b1, r);
    #1;
    chk("wrap_addr", IMEM_Addr, 32'h0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'h0, 1'b1, r);

    // Mid-stream reset restarts the boot count.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, r);
      if (c == 3) chk("reboot_req_c3", 32'(r), 32'h0);
      if (c == 4) chk("reboot_req_c4", 32'(r), 32'h1);
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ((n % 700) == 699) do_reset();
      st  = ($urandom_range(0, 3) == 0);
      sl  = ($urandom_range(0, 11) == 0);
      gn  = ($urandom_range(0, 9) < 7);
      dst = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 1023));
      step(st, sl, dst, gn, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
